// File: rtl/mux_pkg.sv
// Shared select-code constants for the mux4to1_trio selector family.
package mux_pkg;

  localparam logic [1:0] SEL_IN0 = 2'b00;
  localparam logic [1:0] SEL_IN1 = 2'b01;
  localparam logic [1:0] SEL_IN2 = 2'b10;
  localparam logic [1:0] SEL_IN3 = 2'b11;

endpackage

// File: rtl/mux2to1.sv
// Plain 2:1 multiplexer leaf used to build the structural select tree.
module mux2to1 #(
  parameter int WIDTH = 1
) (
  output logic [WIDTH-1:0] out,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s
);

  assign out = s ? b : a;

endmodule

// File: rtl/mux4to1_trio.sv
// 4:1 selector built three ways in parallel; a register stage captures the
// structural result and flags any disagreement between the three paths.
module mux4to1_trio
  import mux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [WIDTH-1:0] out_q,
  output logic             mismatch
);

  logic [WIDTH-1:0] low_pair;
  logic [WIDTH-1:0] high_pair;

  // sel[0] picks within each pair, sel[1] then picks between the pairs
  mux2to1 #(.WIDTH(WIDTH)) u_mux_low (
    .out(low_pair), .a(in0), .b(in1), .s(sel[0])
  );

  mux2to1 #(.WIDTH(WIDTH)) u_mux_high (
    .out(high_pair), .a(in2), .b(in3), .s(sel[0])
  );

  mux2to1 #(.WIDTH(WIDTH)) u_mux_final (
    .out(out1), .a(low_pair), .b(high_pair), .s(sel[1])
  );

  always_comb begin
    out2 = in3;
    if (sel == SEL_IN0)      out2 = in0;
    else if (sel == SEL_IN1) out2 = in1;
    else if (sel == SEL_IN2) out2 = in2;
    else                     out2 = in3;
  end

  always_comb begin
    out3 = in3;
    case (sel)
      SEL_IN0: out3 = in0;
      SEL_IN1: out3 = in1;
      SEL_IN2: out3 = in2;
      SEL_IN3: out3 = in3;
      default: out3 = in3;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q    <= '0;
      mismatch <= 1'b0;
    end else begin
      out_q    <= out1;
      mismatch <= (out1 != out2) | (out1 != out3);
    end
  end

endmodule

// File: tb/tb_mux4to1_trio.sv
// Directed bench for mux4to1_trio: a 1-bit instance for sweeps and a
// byte-wide instance for bit-isolation and asynchronous reset checks.
module tb_mux4to1_trio;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] sel;
  logic       n0, n1, n2, n3;
  logic       n_out1, n_out2, n_out3, n_outq, n_mm;
  logic [7:0] w0, w1, w2, w3;
  logic [7:0] w_out1, w_out2, w_out3, w_outq;
  logic       w_mm;
  int         compared = 0;
  int         mismatched = 0;
  logic       exp_bit;
  logic [3:0] vec;
  logic [7:0] wide_exp [4];

  always #5 clk = ~clk;

  mux4to1_trio #(.WIDTH(1)) dut_narrow (
    .clk(clk), .rst_n(rst_n), .in0(n0), .in1(n1), .in2(n2), .in3(n3),
    .sel(sel), .out1(n_out1), .out2(n_out2), .out3(n_out3),
    .out_q(n_outq), .mismatch(n_mm)
  );

  mux4to1_trio #(.WIDTH(8)) dut_wide (
    .clk(clk), .rst_n(rst_n), .in0(w0), .in1(w1), .in2(w2), .in3(w3),
    .sel(sel), .out1(w_out1), .out2(w_out2), .out3(w_out3),
    .out_q(w_outq), .mismatch(w_mm)
  );

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // vec packs the narrow inputs as {in3,in2,in1,in0}
  task automatic applyStimulus(input logic [1:0] s, input logic [3:0] v);
    sel = s;
    {n3, n2, n1, n0} = v;
    #1;
  endtask

  function automatic logic golden(input logic [1:0] s, input logic [3:0] v);
    return v[s];
  endfunction

  task automatic checkNarrowComb(input string tag, input logic expected);
    checkOutput({tag, " out1"}, {7'b0, n_out1}, {7'b0, expected});
    checkOutput({tag, " out2"}, {7'b0, n_out2}, {7'b0, expected});
    checkOutput({tag, " out3"}, {7'b0, n_out3}, {7'b0, expected});
  endtask

  task automatic checkWideComb(input string tag, input logic [7:0] expected);
    checkOutput({tag, " out1"}, w_out1, expected);
    checkOutput({tag, " out2"}, w_out2, expected);
    checkOutput({tag, " out3"}, w_out3, expected);
  endtask

  initial begin
    rst_n = 1'b0;
    sel = 2'b11;
    {n3, n2, n1, n0} = 4'b1111;
    {w0, w1, w2, w3} = {8'hFF, 8'hFF, 8'hFF, 8'hFF};
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset out_q", {7'b0, n_outq}, 8'h00);
    checkOutput("reset mismatch", {7'b0, n_mm}, 8'h00);
    checkOutput("reset wide out_q", w_outq, 8'h00);
    checkNarrowComb("reset comb", 1'b1);

    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(2'b00, 4'b0001);
    checkNarrowComb("release comb", 1'b1);
    checkOutput("release out_q before edge", {7'b0, n_outq}, 8'h00);
    @(posedge clk); #1;
    checkOutput("release out_q", {7'b0, n_outq}, 8'h01);
    checkOutput("release mismatch", {7'b0, n_mm}, 8'h00);

    // every {sel,in3..in0} combination on the 1-bit instance
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      applyStimulus(k[5:4], k[3:0]);
      exp_bit = golden(k[5:4], k[3:0]);
      checkNarrowComb($sformatf("sweep %0d", k), exp_bit);
      @(posedge clk); #1;
      checkOutput($sformatf("sweep %0d out_q", k), {7'b0, n_outq}, {7'b0, exp_bit});
      checkOutput($sformatf("sweep %0d mismatch", k), {7'b0, n_mm}, 8'h00);
    end

    @(negedge clk);
    applyStimulus(2'b10, 4'b0101);
    checkNarrowComb("directed sel10", 1'b1);
    @(negedge clk);
    applyStimulus(2'b11, 4'b0111);
    checkNarrowComb("directed sel11", 1'b0);
    @(posedge clk); #1;
    checkOutput("directed sel11 out_q", {7'b0, n_outq}, 8'h00);

    for (int r = 0; r < 9; r++) begin
      @(negedge clk);
      vec = 4'($urandom);
      applyStimulus(2'($urandom_range(0, 3)), vec);
      exp_bit = golden(sel, vec);
      checkNarrowComb($sformatf("random %0d", r), exp_bit);
      @(posedge clk); #1;
      checkOutput($sformatf("random %0d out_q", r), {7'b0, n_outq}, {7'b0, exp_bit});
      checkOutput($sformatf("random %0d mismatch", r), {7'b0, n_mm}, 8'h00);
      repeat (4) @(negedge clk);
    end

    wide_exp[0] = 8'hA5;
    wide_exp[1] = 8'h3C;
    wide_exp[2] = 8'hFF;
    wide_exp[3] = 8'h00;
    w0 = 8'hA5; w1 = 8'h3C; w2 = 8'hFF; w3 = 8'h00;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      sel = 2'(s);
      #1;
      checkWideComb($sformatf("wide sel%0d", s), wide_exp[s]);
      @(posedge clk); #1;
      checkOutput($sformatf("wide sel%0d out_q", s), w_outq, wide_exp[s]);
      checkOutput($sformatf("wide sel%0d mismatch", s), {7'b0, w_mm}, 8'h00);
    end

    // reset lands between edges while out_q holds FF
    @(negedge clk);
    sel = 2'b10;
    @(posedge clk); #1;
    checkOutput("pre-reset wide out_q", w_outq, 8'hFF);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset wide out_q", w_outq, 8'h00);
    checkOutput("async reset wide mismatch", {7'b0, w_mm}, 8'h00);
    checkWideComb("async reset comb", 8'hFF);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("post-reset wide out_q", w_outq, 8'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
